// File: rtl/rr_arbiter4_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter4_pkg
// Shared definitions for the four-requester round-robin arbiter:
//   - arbiter state encoding (IDLE / OWNED)
//   - requester count and grant index width
//   - reset value of the round-robin pointer
// ---------------------------------------------------------------------------
package rr_arbiter4_pkg;

   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_t;

   // Pointer starts at the last requester so requester 0 wins first after reset.
   localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

endpackage : rr_arbiter4_pkg

// File: rtl/rr_arbiter4_enc.sv
// ---------------------------------------------------------------------------
// onehot_enc4
// Combinational 4-bit one-hot to 2-bit binary encoder.
// Ports:
//   onehot  in  4 : one-hot input vector (all-zero allowed)
//   idx     out 2 : binary index of the set bit; 2'b00 for zero or
//                   non-one-hot input
// ---------------------------------------------------------------------------
module onehot_enc4
   import rr_arbiter4_pkg::*;
(
   input  logic [NREQ-1:0]  onehot,
   output logic [IDX_W-1:0] idx
);

   // One-hot to binary lookup; anything not strictly one-hot maps to 0.
   always_comb begin
      idx = 2'b00;
      case (onehot)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'b00;
      endcase
   end

endmodule : onehot_enc4

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter with a registered one-hot grant.
// A granted owner keeps the resource while its request stays high; at
// least one idle cycle separates consecutive owners.
//
// Optional feature (macro RR_ARB_TIMEOUT_EN): a hold counter revokes a
// grant after HOLD_MAX cycles, pulses `timeout`, and masks the revoked
// requester until it drops its request.
//
// Parameters:
//   HOLD_MAX        maximum grant length in cycles (1..15), timeout build only
// Ports:
//   clk      in  1 : clock, rising edge
//   rst_n    in  1 : asynchronous active-low reset
//   req      in  4 : level requests, bit i = requester i
//   gnt      out 4 : registered one-hot grant, zero when no owner
//   gnt_idx  out 2 : binary index of gnt, 0 when gnt is zero
//   gnt_vld  out 1 : high while any gnt bit is high
//   timeout  out 1 : one-cycle pulse on forced revocation (0 without macro)
// ---------------------------------------------------------------------------
module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 15
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic             timeout
);

   if ((HOLD_MAX < 1) || (HOLD_MAX > 15)) begin : g_hold_max_check
      $error("rr_arbiter4: HOLD_MAX must be in 1..15");
   end

   arb_state_t       state_r;
   arb_state_t       state_nxt_s;
   logic [NREQ-1:0]  gnt_r;
   logic [NREQ-1:0]  gnt_nxt_s;
   logic [IDX_W-1:0] last_r;
   logic [IDX_W-1:0] last_nxt_s;
   logic [NREQ-1:0]  eff_req_s;
   logic [IDX_W:0]   pick_s;
   logic             owner_req_s;
   logic             hold_expire_s;
   logic             revoke_s;

   // Scan last+1, last+2, last+3, last (mod 4); returns {found, index}.
   // Walk from lowest to highest priority so the nearest candidate wins.
   function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0]  req_i,
                                               input logic [IDX_W-1:0] last_i);
      logic [IDX_W-1:0] cand;
      logic [IDX_W:0]   res;
      res = 3'b000;
      for (int k = NREQ; k >= 1; k--) begin
         cand = last_i + IDX_W'(k);
         if (req_i[cand]) begin
            res = {1'b1, cand};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

`ifdef RR_ARB_TIMEOUT_EN
   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   logic [3:0]      hold_cnt_r;
   logic [3:0]      hold_cnt_nxt_s;
   logic [NREQ-1:0] mask_r;
   logic [NREQ-1:0] mask_nxt_s;
   logic            timeout_r;

   // Counter value after this edge equals the number of granted cycles
   // completed, so reaching HOLD_LIM here means the owner has used its quota.
   always_comb begin
      hold_expire_s = ((hold_cnt_r + 4'd1) == HOLD_LIM);
      eff_req_s     = req & ~mask_r;
   end

   // Counter runs only across consecutive OWNED cycles; mask bits drop with req.
   always_comb begin
      hold_cnt_nxt_s = 4'd0;
      mask_nxt_s     = mask_r & req;
      if ((state_r == ST_OWNED) && (state_nxt_s == ST_OWNED)) begin
         hold_cnt_nxt_s = hold_cnt_r + 4'd1;
      end else begin
         hold_cnt_nxt_s = 4'd0;
      end
      if (revoke_s) begin
         mask_nxt_s = (mask_r & req) | gnt_r;
      end else begin
         mask_nxt_s = mask_r & req;
      end
   end

   // Hold counter, revocation mask and timeout pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= 4'd0;
         mask_r     <= 4'b0000;
         timeout_r  <= 1'b0;
      end else begin
         hold_cnt_r <= hold_cnt_nxt_s;
         mask_r     <= mask_nxt_s;
         timeout_r  <= revoke_s;
      end
   end

   assign timeout = timeout_r;
`else
   // Grants are never revoked in this build.
   always_comb begin
      hold_expire_s = 1'b0;
      eff_req_s     = req;
   end

   assign timeout = 1'b0;
`endif

   // Next-state, next-grant and pointer update.
   always_comb begin
      state_nxt_s = state_r;
      gnt_nxt_s   = gnt_r;
      last_nxt_s  = last_r;
      revoke_s    = 1'b0;
      pick_s      = rr_pick(eff_req_s, last_r);
      owner_req_s = |(req & gnt_r);
      case (state_r)
         ST_IDLE: begin
            if (pick_s[IDX_W]) begin
               gnt_nxt_s   = 4'b0001 << pick_s[IDX_W-1:0];
               last_nxt_s  = pick_s[IDX_W-1:0];
               state_nxt_s = ST_OWNED;
            end else begin
               gnt_nxt_s   = 4'b0000;
               state_nxt_s = ST_IDLE;
            end
         end
         ST_OWNED: begin
            // Release always goes through IDLE; no same-edge regrant.
            if (!owner_req_s) begin
               gnt_nxt_s   = 4'b0000;
               state_nxt_s = ST_IDLE;
            end else if (hold_expire_s) begin
               gnt_nxt_s   = 4'b0000;
               state_nxt_s = ST_IDLE;
               revoke_s    = 1'b1;
            end else begin
               gnt_nxt_s   = gnt_r;
               state_nxt_s = ST_OWNED;
            end
         end
         default: begin
            gnt_nxt_s   = 4'b0000;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         gnt_r   <= 4'b0000;
         last_r  <= LAST_RST;
      end else begin
         state_r <= state_nxt_s;
         gnt_r   <= gnt_nxt_s;
         last_r  <= last_nxt_s;
      end
   end

   onehot_enc4 u_enc (
      .onehot (gnt_r),
      .idx    (gnt_idx)
   );

   assign gnt     = gnt_r;
   assign gnt_vld = |gnt_r;

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4
// Directed bench for rr_arbiter4: a table of per-cycle {req, expected gnt,
// expected gnt_idx} records plus hand-written reset and hold-limit sequences.
// Build with RR_ARB_TIMEOUT_EN to exercise the revocation path (HOLD_MAX=4).
// ---------------------------------------------------------------------------
module tb_rr_arbiter4;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int n_tests;
   int n_fail;

   vec_t tbl [0:25];

   rr_arbiter4 #(.HOLD_MAX(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] exp_of(input logic [3:0] g, input logic [1:0] i,
                                         input logic t);
      return {g, i, (g != 4'b0000), t};
   endfunction

   task automatic chk(input string name, input logic [7:0] exp);
      logic [7:0] act;
      act = {gnt, gnt_idx, gnt_vld, timeout};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got gnt/idx/vld/to=%b required %b at %0t", name, act, exp, $time);
      end
   endtask

   // Drive req on the falling edge, then sample just after the next rising edge.
   task automatic step(input logic [3:0] r);
      @(negedge clk);
      req = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // fairness: each owner drops req for one cycle after two granted cycles
      tbl[0]  = '{4'b1111, 4'b0001, 2'd0};
      tbl[1]  = '{4'b1111, 4'b0001, 2'd0};
      tbl[2]  = '{4'b1110, 4'b0000, 2'd0};
      tbl[3]  = '{4'b1111, 4'b0010, 2'd1};
      tbl[4]  = '{4'b1111, 4'b0010, 2'd1};
      tbl[5]  = '{4'b1101, 4'b0000, 2'd0};
      tbl[6]  = '{4'b1111, 4'b0100, 2'd2};
      tbl[7]  = '{4'b1111, 4'b0100, 2'd2};
      tbl[8]  = '{4'b1011, 4'b0000, 2'd0};
      tbl[9]  = '{4'b1111, 4'b1000, 2'd3};
      tbl[10] = '{4'b1111, 4'b1000, 2'd3};
      tbl[11] = '{4'b0111, 4'b0000, 2'd0};
      tbl[12] = '{4'b1111, 4'b0001, 2'd0};
      tbl[13] = '{4'b1111, 4'b0001, 2'd0};
      tbl[14] = '{4'b1110, 4'b0000, 2'd0};
      // skip: last=0, req=1001 -> 3
      tbl[15] = '{4'b1001, 4'b1000, 2'd3};
      tbl[16] = '{4'b0000, 4'b0000, 2'd0};
      // set last=1, then req=0001 wraps to 0
      tbl[17] = '{4'b0010, 4'b0010, 2'd1};
      tbl[18] = '{4'b0000, 4'b0000, 2'd0};
      tbl[19] = '{4'b0001, 4'b0001, 2'd0};
      tbl[20] = '{4'b0000, 4'b0000, 2'd0};
      // release during contention: owner 2 drops while req[0] high
      tbl[21] = '{4'b0100, 4'b0100, 2'd2};
      tbl[22] = '{4'b0101, 4'b0100, 2'd2};
      tbl[23] = '{4'b0001, 4'b0000, 2'd0};
      tbl[24] = '{4'b0001, 4'b0001, 2'd0};
      tbl[25] = '{4'b0000, 4'b0000, 2'd0};

      // reset held with all requests asserted
      rst_n = 1'b0;
      req   = 4'b1111;
      #2;
      chk("reset_async", exp_of(4'b0000, 2'd0, 1'b0));
      repeat (3) @(posedge clk);
      #1;
      chk("reset_held", exp_of(4'b0000, 2'd0, 1'b0));
      rst_n = 1'b1;

      for (int i = 0; i < 26; i++) begin
         step(tbl[i].req);
         chk($sformatf("vec%0d", i), exp_of(tbl[i].gnt, tbl[i].idx, 1'b0));
      end

      // asynchronous reset in the middle of a grant to requester 2
      step(4'b0100);
      chk("pre_rst_gnt2", exp_of(4'b0100, 2'd2, 1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_grant_rst", exp_of(4'b0000, 2'd0, 1'b0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(4'b1111);
      chk("post_rst_gnt0", exp_of(4'b0001, 2'd0, 1'b0));
      step(4'b0000);
      chk("post_rst_rel", exp_of(4'b0000, 2'd0, 1'b0));

      // requester 1 holds permanently while requester 3 waits
`ifdef RR_ARB_TIMEOUT_EN
      for (int c = 0; c < 4; c++) begin
         step(4'b1010);
         chk($sformatf("hold1_c%0d", c), exp_of(4'b0010, 2'd1, 1'b0));
      end
      step(4'b1010);
      chk("revoke1", exp_of(4'b0000, 2'd0, 1'b1));
      step(4'b1010);
      chk("gnt3_after_to", exp_of(4'b1000, 2'd3, 1'b0));
      step(4'b0010);
      chk("rel3", exp_of(4'b0000, 2'd0, 1'b0));
      for (int c = 0; c < 3; c++) begin
         step(4'b0010);
         chk($sformatf("masked1_c%0d", c), exp_of(4'b0000, 2'd0, 1'b0));
      end
      step(4'b0000);
      chk("unmask1", exp_of(4'b0000, 2'd0, 1'b0));
      step(4'b0010);
      chk("regrant1", exp_of(4'b0010, 2'd1, 1'b0));
`else
      for (int c = 0; c < 22; c++) begin
         step(4'b1010);
         chk($sformatf("hold1_c%0d", c), exp_of(4'b0010, 2'd1, 1'b0));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rr_arbiter4
